// File: rtl/apple2_pkg.sv
// rtl/apple2_pkg.sv - shared types and helpers for the NIB track sequencer
package apple2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  localparam int NIB_SECS = 13;

  // 13*t as shifts and adds so no multiplier is inferred
  function automatic logic [31:0] lba_base(input logic [31:0] t);
    return (t << 3) + (t << 2) + t;
  endfunction

endpackage

// File: rtl/nib_track_sync_if.sv
// rtl/nib_track_sync_if.sv - SD block request/ack bundle between sequencer and hps_io
interface nib_track_sync_if;

  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;

  modport master (
    output sd_lba,
    output sd_rd,
    output sd_wr,
    input  sd_ack
  );

  modport slave (
    input  sd_lba,
    input  sd_rd,
    input  sd_wr,
    output sd_ack
  );

endinterface

// File: rtl/sd_edge.sv
// rtl/sd_edge.sv - registers sd_ack and reports its rising and falling edges
module sd_edge (
  input  logic clk_sys,
  input  logic reset,
  input  logic sd_ack,
  output logic ack_rise,
  output logic ack_fall
);

  logic old_ack;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      old_ack <= 1'b0;
    end else begin
      old_ack <= sd_ack;
    end
  end

  assign ack_rise = ~old_ack & sd_ack;
  assign ack_fall = old_ack & ~sd_ack;

endmodule

// File: rtl/nib_track_sync.sv
// rtl/nib_track_sync.sv - writes back a dirty resident NIB track and loads the new
// head track over the SD block interface, stalling the CPU meanwhile
module nib_track_sync
  import apple2_pkg::*;
#(
  parameter int SECS  = NIB_SECS,
  parameter int TRK_W = 6,
  parameter int SEC_W = 4
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic [TRK_W-1:0]     track,
  input  logic                 track_dirty,
  output logic                 dirty_clr,
  input  logic                 img_mounted,
  input  logic                 img_present,
  nib_track_sync_if.master     sd,
  output logic [SEC_W-1:0]     track_sec,
  output logic                 cpu_wait,
  output logic                 busy,
  output logic                 res_valid,
  output logic [TRK_W-1:0]     res_track
);

  state_t             state;
  logic               remount_pend;
  logic [TRK_W-1:0]   target;
  logic [31:0]        lba;
  logic               rd;
  logic               wr;
  logic               ack_rise;
  logic               ack_fall;
  logic               last_sec;
  logic               idle_start;
  logic               idle_wr;
  logic [TRK_W-1:0]   idle_tgt;

  sd_edge u_sd_edge (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .sd_ack   (sd.sd_ack),
    .ack_rise (ack_rise),
    .ack_fall (ack_fall)
  );

  assign sd.sd_lba = lba;
  assign sd.sd_rd  = rd;
  assign sd.sd_wr  = wr;
  assign busy      = (state != IDLE);
  assign last_sec  = (track_sec == SEC_W'(SECS - 1));

  // A pending remount suppresses write-back: the dirty data belongs to the old image
  always_comb begin
    idle_start = 1'b0;
    idle_wr    = 1'b0;
    idle_tgt   = track;
    if (remount_pend || !res_valid || (track != res_track)) begin
      idle_start = img_present;
    end
    if (!remount_pend && res_valid && (track != res_track) && track_dirty) begin
      idle_wr  = 1'b1;
      idle_tgt = res_track;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      remount_pend <= 1'b0;
      target       <= '0;
      lba          <= '0;
      rd           <= 1'b0;
      wr           <= 1'b0;
      track_sec    <= '0;
      cpu_wait     <= 1'b0;
      dirty_clr    <= 1'b0;
      res_valid    <= 1'b0;
      res_track    <= '0;
    end else begin
      dirty_clr <= 1'b0;
      case (state)
        IDLE: begin
          if (remount_pend) begin
            remount_pend <= 1'b0;
            res_valid    <= 1'b0;
          end else if (!img_present) begin
            res_valid <= 1'b0;
          end
          if (idle_start) begin
            state     <= idle_wr ? WRITE : READ;
            target    <= idle_tgt;
            track_sec <= '0;
            lba       <= lba_base(32'(idle_tgt));
            rd        <= ~idle_wr;
            wr        <= idle_wr;
            cpu_wait  <= 1'b1;
          end
        end

        WRITE, READ: begin
          if (ack_rise) begin
            lba <= lba + 32'd1;
            if (last_sec) begin
              rd <= 1'b0;
              wr <= 1'b0;
            end
          end
          if (ack_fall) begin
            track_sec <= last_sec ? '0 : track_sec + SEC_W'(1);
            // Request already dropped on the last rise, so this fall ends the transfer
            if (!rd && !wr) begin
              if (state == WRITE) begin
                dirty_clr <= 1'b1;
                state     <= READ;
                target    <= track;
                track_sec <= '0;
                lba       <= lba_base(32'(track));
                rd        <= 1'b1;
              end else begin
                res_track <= target;
                res_valid <= 1'b1;
                cpu_wait  <= 1'b0;
                state     <= IDLE;
              end
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase

      if (img_mounted) begin
        remount_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nib_track_sync.sv
// tb/tb_nib_track_sync.sv - randomized hps_io responder with sector scoreboard for nib_track_sync
module tb_nib_track_sync;

  localparam int SECS  = 13;
  localparam int TRK_W = 6;
  localparam int SEC_W = 4;

  typedef struct packed {
    logic        wr;
    logic [31:0] lba;
    logic [3:0]  sec;
  } sec_t;

  logic             clk_sys = 1'b0;
  logic             reset = 1'b1;
  logic [TRK_W-1:0] track = '0;
  logic             track_dirty = 1'b0;
  logic             img_mounted = 1'b0;
  logic             img_present = 1'b0;
  logic             dirty_clr;
  logic [SEC_W-1:0] track_sec;
  logic             cpu_wait;
  logic             busy;
  logic             res_valid;
  logic [TRK_W-1:0] res_track;

  nib_track_sync_if sd_if ();

  nib_track_sync #(
    .SECS  (SECS),
    .TRK_W (TRK_W),
    .SEC_W (SEC_W)
  ) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .track       (track),
    .track_dirty (track_dirty),
    .dirty_clr   (dirty_clr),
    .img_mounted (img_mounted),
    .img_present (img_present),
    .sd          (sd_if),
    .track_sec   (track_sec),
    .cpu_wait    (cpu_wait),
    .busy        (busy),
    .res_valid   (res_valid),
    .res_track   (res_track)
  );

  always #5 clk_sys = ~clk_sys;

  sec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   dclr_cnt = 0;
  int   wait_gaps = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: a transfer of track t touches LBAs 13*t .. 13*t+n-1 in order
  task automatic push_xfer(input bit wr, input int trk, input int n);
    for (int i = 0; i < n; i++) begin
      sec_t s;
      s.wr  = wr;
      s.lba = 32'(SECS * trk + i);
      s.sec = 4'(i);
      exp_q.push_back(s);
    end
  endtask

  // hps_io model: random ack width and inter-sector gap
  initial begin
    int hold;
    int gap;
    sd_if.sd_ack = 1'b0;
    hold = 0;
    gap  = 2;
    forever begin
      @(negedge clk_sys);
      if (reset) begin
        sd_if.sd_ack = 1'b0;
        gap = 2;
      end else if (sd_if.sd_ack) begin
        if (hold == 0) begin
          sd_if.sd_ack = 1'b0;
          gap = int'($urandom_range(1, 3));
        end else begin
          hold--;
        end
      end else if (gap > 0) begin
        gap--;
      end else if (sd_if.sd_rd || sd_if.sd_wr) begin
        sd_if.sd_ack = 1'b1;
        hold = int'($urandom_range(0, 3));
      end
    end
  end

  // Monitor: every ack rise is one sector; compare request against the scoreboard
  initial begin
    logic prev_ack;
    sec_t e;
    prev_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      #2;
      if (reset) begin
        prev_ack = 1'b0;
      end else begin
        if (busy && !cpu_wait) wait_gaps++;
        if (dirty_clr) dclr_cnt++;
        if (sd_if.sd_ack && !prev_ack) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_sector actual=lba %0d rd %0b wr %0b expected=no request",
                     sd_if.sd_lba, sd_if.sd_rd, sd_if.sd_wr);
          end else begin
            e = exp_q.pop_front();
            chk("sec_rdwr", {sd_if.sd_wr, sd_if.sd_rd}, {e.wr, ~e.wr});
            chk("sec_lba", sd_if.sd_lba, e.lba);
            chk("sec_idx", track_sec, e.sec);
          end
        end
        prev_ack = sd_if.sd_ack;
      end
    end
  end

  task automatic wait_idle(input string name);
    int quiet;
    quiet = 0;
    for (int cyc = 0; cyc < 3000 && quiet < 4; cyc++) begin
      @(negedge clk_sys);
      #3;
      if (dirty_clr) track_dirty = 1'b0;
      if (!busy && exp_q.size() == 0) quiet++;
      else quiet = 0;
    end
    checks++;
    if (quiet < 4) begin
      errors++;
      $display("FAIL %s_timeout actual=busy %0b pending %0d expected=idle with 0 pending",
               name, busy, exp_q.size());
    end
  endtask

  task automatic wait_sector(input int s);
    bit hit;
    hit = 1'b0;
    for (int cyc = 0; cyc < 3000 && !hit; cyc++) begin
      @(negedge clk_sys);
      #3;
      if (sd_if.sd_ack && track_sec == SEC_W'(s)) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL wait_sector_timeout actual=not reached expected=sector %0d ack", s);
    end
  endtask

  task automatic check_resident(input int trk);
    chk("res_valid", res_valid, 1);
    chk("res_track", res_track, 64'(trk));
    chk("cpu_wait_idle", cpu_wait, 0);
    chk("req_idle", {sd_if.sd_rd, sd_if.sd_wr}, 0);
  endtask

  initial begin
    int m_track;
    int nt;
    int d;
    int base;

    repeat (2) @(negedge clk_sys);
    chk("rst_outputs", {sd_if.sd_lba, sd_if.sd_rd, sd_if.sd_wr, dirty_clr, track_sec,
                        cpu_wait, busy, res_valid, res_track}, 0);
    reset = 1'b0;

    // Mount with no image: nothing may start
    img_mounted = 1'b1;
    @(negedge clk_sys);
    img_mounted = 1'b0;
    repeat (3) @(negedge clk_sys);
    chk("absent_idle", {sd_if.sd_rd, sd_if.sd_wr, cpu_wait, res_valid}, 0);

    push_xfer(0, 0, SECS);
    img_present = 1'b1;
    wait_idle("mount");
    check_resident(0);
    chk("mount_no_dclr", dclr_cnt, 0);

    // Clean track change: read only
    push_xfer(0, 17, SECS);
    track = 6'd17;
    @(negedge clk_sys);
    @(negedge clk_sys);
    #3;
    chk("latency_rd", sd_if.sd_rd, 1);
    chk("latency_wait", cpu_wait, 1);
    wait_idle("trk17");
    check_resident(17);
    chk("trk17_no_dclr", dclr_cnt, 0);

    push_xfer(0, 5, SECS);
    track = 6'd5;
    wait_idle("trk5");
    check_resident(5);

    // Dirty track 5 leaving for 6: write-back then read
    push_xfer(1, 5, SECS);
    push_xfer(0, 6, SECS);
    track_dirty = 1'b1;
    track = 6'd6;
    wait_idle("wb6");
    check_resident(6);
    chk("wb_dclr_once", dclr_cnt, 1);
    chk("wb_no_wait_gap", wait_gaps, 0);

    // Remount mid-read: finish, then reread the same track
    push_xfer(0, 9, SECS);
    push_xfer(0, 9, SECS);
    track = 6'd9;
    wait_sector(3);
    img_mounted = 1'b1;
    @(negedge clk_sys);
    #3;
    img_mounted = 1'b0;
    wait_idle("remount");
    check_resident(9);

    // Reset while sector 7 ack is high
    push_xfer(0, 20, 8);
    track = 6'd20;
    wait_sector(7);
    reset = 1'b1;
    #1;
    chk("rst_async", {sd_if.sd_lba, sd_if.sd_rd, sd_if.sd_wr, dirty_clr, track_sec,
                      cpu_wait, busy, res_valid, res_track}, 0);
    repeat (3) @(negedge clk_sys);
    #3;
    chk("rst_pending", exp_q.size(), 0);
    push_xfer(0, 20, SECS);
    reset = 1'b0;
    wait_idle("post_rst");
    check_resident(20);

    // Random track walk with random dirtiness
    m_track = 20;
    for (int k = 0; k < 5; k++) begin
      do nt = int'($urandom_range(0, 63)); while (nt == m_track);
      d = int'($urandom_range(0, 1));
      base = dclr_cnt;
      if (d != 0) push_xfer(1, m_track, SECS);
      push_xfer(0, nt, SECS);
      track_dirty = (d != 0);
      track = TRK_W'(nt);
      wait_idle("rand");
      check_resident(nt);
      chk("rand_dclr", dclr_cnt - base, 64'(d));
      m_track = nt;
    end
    chk("no_wait_gap", wait_gaps, 0);

    // Image removed: res_valid drops and a track change starts nothing
    img_present = 1'b0;
    repeat (3) @(negedge clk_sys);
    #3;
    chk("absent_res_valid", res_valid, 0);
    track = TRK_W'(m_track) ^ 6'h2A;
    repeat (15) @(negedge clk_sys);
    #3;
    chk("absent_no_xfer", {sd_if.sd_rd, sd_if.sd_wr, cpu_wait, busy, res_valid}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nib_track_sync.md
Name: nib_track_sync

Overview:
- Sequences NIB-image track transfers between the HPS SD block interface and the on-chip track buffer.
- On a head-track change it writes back the resident track if the disk emulation dirtied it, then reads the new track.
- Holds the CPU stalled (cpu_wait) for the whole transfer.
- Sits between hps_io (sd_* ports) and apple2_top (TRACK, TRACK_RAM_ADDR high bits, CPU_WAIT); replaces the read-only loader in emu.

Parameters:
- SECS, 13, 512-byte SD sectors per NIB track (6656 bytes).
- TRK_W, 6, track number width.
- SEC_W, 4, sector index width; must satisfy 2^SEC_W >= SECS.

Ports:
- clk_sys  in  1  system clock (14 MHz domain); all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- track  in  TRK_W  current head track from the drive model.
- track_dirty  in  1  level: resident track buffer was written by the drive model.
- dirty_clr  out  1  one-cycle pulse when write-back of the resident track completes.
- img_mounted  in  1  one-cycle pulse: new image mounted.
- img_present  in  1  image size non-zero.
- sd_lba  out  32  block address.
- sd_rd  out  1  read request to hps_io.
- sd_wr  out  1  write request to hps_io.
- sd_ack  in  1  hps_io ack; high for the duration of each sector transfer.
- track_sec  out  SEC_W  sector index; forms the high bits of the track-buffer address.
- cpu_wait  out  1  CPU stall.
- busy  out  1  state != IDLE.
- res_valid  out  1  the resident buffer holds res_track of the current image.
- res_track  out  TRK_W  track number held in the buffer.

Behaviour:
- Reset values: all outputs 0. Internal state: state=IDLE, remount_pend=0, old_ack=0.
- States: IDLE, WRITE, READ.
- Sector base address: lba_base(t) = 13*t, computed as (t<<3)+(t<<2)+t and zero-extended to 32 bits. No multiplier.

IDLE, evaluated in priority order every cycle:
1. remount_pend: clear it, clear res_valid, drop any dirty data (no write-back to the new image), then start READ.
2. res_valid & track != res_track & track_dirty: start WRITE of res_track.
3. track != res_track, or !res_valid: start READ of track.

Starting a transfer:
- A transfer starts only if img_present. If !img_present, stay in IDLE with res_valid=0 and cpu_wait=0.
- Start actions, registered: track_sec<=0; sd_lba<=lba_base(target); assert sd_rd (READ) or sd_wr (WRITE); cpu_wait<=1.

Sector handshake (WRITE and READ identical):
- old_ack is sd_ack registered. A rising edge of sd_ack is sampled as ~old_ack & sd_ack; a falling edge as old_ack & ~sd_ack.
- Ack rise: sd_lba<=sd_lba+1. If track_sec==SECS-1, drop the request (sd_rd/sd_wr<=0).
- Ack fall: track_sec<=track_sec+1. If the request is already low, the transfer is complete.
- The request stays continuously high across sectors 0..SECS-1. Exactly SECS ack pulses per transfer.

Completion:
- WRITE complete: dirty_clr pulses 1 cycle, then go straight to READ of the current track. cpu_wait stays 1, with no deassert gap.
- READ complete: res_track<=target, res_valid<=1, cpu_wait<=0, state<=IDLE.
- Latency from track change to first request: 2 cycles (IDLE compare, then registered request).

Boundary conditions:
- img_mounted arriving while not IDLE sets remount_pend. The current transfer finishes, and the handshake is never abandoned.
- Track changes during a transfer are ignored until IDLE, then re-evaluated. The result is a new read of the latest track, with no write-back, because the buffer was just freshly loaded.
- track_sec wraps to 0 after the final fall. Its value is don't-care in IDLE.
- sd_ack edges seen in IDLE are ignored.
- Reset mid-transfer: return to the reset values immediately. Dirty data is lost. hps_io recovers on the next request.
- img_present falling in IDLE: res_valid<=0.

Decomposition:
- Package apple2_pkg:
  - typedef state_t {IDLE, WRITE, READ}
  - localparam NIB_SECS=13
  - function lba_base(track)
- One sub-module, sd_edge: registered sd_ack with rise/fall outputs. Everything else stays in one always_ff.

Test Plan:
- Mount with img_present=1, track=0 → sd_rd high, sd_lba 0..12 over 13 ack pulses, then res_valid=1, res_track=0, cpu_wait=0.
- Track 0→17, not dirty → READ only. First sd_lba=221, last=233. No sd_wr, no dirty_clr.
- Track 5 resident and dirty, track→6 → sd_wr with lba 65..77, dirty_clr pulse, then sd_rd with lba 78..90, cpu_wait high throughout with no gap.
- img_mounted pulse during the 4th sector of a read → the read completes all 13 sectors, then a new read of the current track is issued even though the track number is unchanged.
- reset asserted while sd_ack is high in sector 7 → all outputs 0 asynchronously. After release with a track present, a fresh READ from sector 0 starts.
- img_present=0 with a track change → no sd_rd/sd_wr, cpu_wait stays 0, res_valid=0.
